// File: rtl/seq_magnitude_comparator_pkg.sv
// -----------------------------------------------------------------------------
// comparator_pkg
// Shared types for the sequential magnitude comparator:
//   state_t      - FSM states of the scanning comparator
//   cmp_result_t - three-flag result {eq, gt, lt}, same encoding as the
//                  single-bit EQ/GT/LT comparator
//   CMP_*        - one-hot result constants (CMP_NONE is the reset value)
// -----------------------------------------------------------------------------
package comparator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic eq;
      logic gt;
      logic lt;
   } cmp_result_t;

   localparam cmp_result_t CMP_NONE = '{eq: 1'b0, gt: 1'b0, lt: 1'b0};
   localparam cmp_result_t CMP_EQ   = '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
   localparam cmp_result_t CMP_GT   = '{eq: 1'b0, gt: 1'b1, lt: 1'b0};
   localparam cmp_result_t CMP_LT   = '{eq: 1'b0, gt: 1'b0, lt: 1'b1};

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// -----------------------------------------------------------------------------
// seq_magnitude_comparator_if
// Start/done handshake and operand/result bus of the sequential comparator.
//   start, signed_mode, a, b        : requester -> comparator
//   busy, done, a_eq_b/a_gt_b/a_lt_b : comparator -> requester
// Modports: master = requester side, slave = comparator side.
// -----------------------------------------------------------------------------
interface seq_magnitude_comparator_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             a_eq_b;
   logic             a_gt_b;
   logic             a_lt_b;

   modport master (
      output start, signed_mode, a, b,
      input  busy, done, a_eq_b, a_gt_b, a_lt_b
   );

   modport slave (
      input  start, signed_mode, a, b,
      output busy, done, a_eq_b, a_gt_b, a_lt_b
   );
endinterface

// File: rtl/seq_magnitude_comparator_slice.sv
// -----------------------------------------------------------------------------
// slice_compare
// Combinational unsigned compare of one DIGIT-bit slice.
//   x, y   : slice operands
//   eq/gt/lt : exactly one is high
// Scans MSB-first; the first differing bit decides the order, which is the
// multi-bit generalisation of the single-bit EQ/GT/LT comparator.
// -----------------------------------------------------------------------------
module slice_compare #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   output logic             eq,
   output logic             gt,
   output logic             lt
);
   always_comb begin
      gt = 1'b0;
      lt = 1'b0;
      for (int i = DIGIT - 1; i >= 0; i--) begin
         if (!gt && !lt) begin
            if (x[i] && !y[i]) begin
               gt = 1'b1;
            end else if (!x[i] && y[i]) begin
               lt = 1'b1;
            end
         end
      end
      eq = !gt && !lt;
   end
endmodule

// File: rtl/seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// seq_magnitude_comparator
// Sequential WIDTH-bit magnitude comparator (unsigned or two's complement).
// Operands are scanned MSB-first, one DIGIT-bit slice per clock; the scan
// stops at the first differing slice.
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : slave side of seq_magnitude_comparator_if
//            (start/signed_mode/a/b in, busy/done/a_eq_b/a_gt_b/a_lt_b out)
// -----------------------------------------------------------------------------
module seq_magnitude_comparator
   import comparator_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input logic                       clk,
   input logic                       rst_n,
   seq_magnitude_comparator_if.slave bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [IW-1:0]    idx_q, idx_d;
   cmp_result_t      res_q, res_d;

   logic [DIGIT-1:0] a_sl [NDIG];
   logic [DIGIT-1:0] b_sl [NDIG];
   logic             sl_eq, sl_gt, sl_lt;

   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_slice
         assign a_sl[gi] = a_q[gi*DIGIT +: DIGIT];
         assign b_sl[gi] = b_q[gi*DIGIT +: DIGIT];
      end
   endgenerate

   slice_compare #(.DIGIT(DIGIT)) u_slice (
      .x  (a_sl[idx_q]),
      .y  (b_sl[idx_q]),
      .eq (sl_eq),
      .gt (sl_gt),
      .lt (sl_lt)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      res_d   = res_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               // Flipping the sign bits maps two's-complement order onto
               // unsigned order, so the scan itself never needs the mode.
               a_d = bus.a;
               b_d = bus.b;
               if (bus.signed_mode) begin
                  a_d[WIDTH-1] = ~bus.a[WIDTH-1];
                  b_d[WIDTH-1] = ~bus.b[WIDTH-1];
               end
               idx_d   = IW'(NDIG - 1);
               state_d = SCAN;
            end else begin
               state_d = IDLE;
            end
         end
         SCAN: begin
            if (!sl_eq) begin
               res_d   = '{eq: 1'b0, gt: sl_gt, lt: sl_lt};
               state_d = DONE;
            end else if (idx_q == '0) begin
               res_d   = CMP_EQ;
               state_d = DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         res_q   <= CMP_NONE;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
      end
   end

   assign bus.busy   = (state_q == SCAN);
   assign bus.done   = (state_q == DONE);
   assign bus.a_eq_b = res_q.eq;
   assign bus.a_gt_b = res_q.gt;
   assign bus.a_lt_b = res_q.lt;
endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised multi-bit magnitude comparator for operands of WIDTH bits. It supports unsigned and two's-complement signed modes and uses a start/done handshake. The block scans operands MSB-first, one DIGIT-bit slice per clock, and terminates early on the first differing slice. It is the sequential, wide-operand successor to the team's single-bit EQ/GT/LT comparator and keeps that comparator's three-flag result encoding.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits compared per clock; 1 <= DIGIT <= WIDTH.
NDIG (localparam), WIDTH/DIGIT, number of slices.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
start  input  1  request a comparison; sampled only when busy=0.
signed_mode  input  1  1 = two's-complement compare; 0 = unsigned; captured with start.
a  input  WIDTH  operand A; captured with start.
b  input  WIDTH  operand B; captured with start.
busy  output  1  high while state = SCAN.
done  output  1  single-cycle pulse; result flags are valid in the same cycle.
a_eq_b  output  1  A == B result flag.
a_gt_b  output  1  A > B result flag.
a_lt_b  output  1  A < B result flag.

Behaviour:
- Reset: clk is the only clock; rst_n is synchronous and active-low. While rst_n=0 at an edge: state=IDLE, busy=0, done=0, a_eq_b=a_gt_b=a_lt_b=0, slice index=0. Reset mid-SCAN aborts the comparison with no done pulse.
- FSM states:
  - IDLE: start=1 at an edge -> capture a, b, signed_mode -> SCAN, index=NDIG-1.
  - SCAN: compare slice[index] of both operands.
    - If the slices differ: update the flags -> DONE.
    - Else if index=0: a_eq_b=1 -> DONE.
    - Else: index-1, stay in SCAN.
  - DONE: done=1 for exactly this one cycle.
    - start=1: accepted as in IDLE (back-to-back) -> SCAN.
    - Otherwise -> IDLE.
- start while busy=1 is ignored; the captured operands and mode are not disturbed.
- Signed mode: at capture, invert bit WIDTH-1 of both operands. An unsigned compare of the results equals the signed order. No other path depends on mode.
- Result flags are registered and exactly one-hot after the first completed compare.
  - Flags are updated only on the edge entering DONE.
  - They hold their value through IDLE and subsequent SCANs until the next update.
- Latency: with start sampled at edge E0 and k = 1 + (NDIG-1 - index of first differing slice), or k=NDIG if the operands are equal:
  - done is high in the cycle following edge Ek.
  - Minimum latency is 1 cycle after capture; maximum is NDIG.
- Operand inputs a and b are don't-care except at the capture edge.
- DIGIT=WIDTH degenerates to a single-cycle compare, still with the same handshake.

Decomposition:
- Package comparator_pkg:
  - state enum {IDLE, SCAN, DONE};
  - cmp_result_t struct {eq, gt, lt};
  - constants CMP_EQ/CMP_GT/CMP_LT.
- Sub-module slice_compare: combinational, parameter DIGIT, inputs x[DIGIT] and y[DIGIT], outputs eq/gt/lt. This generalises the single-bit comparator.
- The top level holds the FSM, the operand registers, the index counter and the result registers.

Test Plan (WIDTH=16, DIGIT=4):
1. rst_n=0 for 2 edges with start=1 -> busy=done=a_eq_b=a_gt_b=a_lt_b=0; no capture.
2. Unsigned a=0x1234, b=0x1234, start for 1 cycle -> busy for 4 cycles, then done pulse with a_eq_b=1, gt=lt=0 (latency 4).
3. a=0x8000, b=0x7FFF:
   - signed_mode=0 -> done at latency 1, a_gt_b=1.
   - Repeat with signed_mode=1 -> done at latency 1, a_lt_b=1.
4. Unsigned a=0x12F0, b=0x12E0 -> done at latency 3 with a_gt_b=1. Then a=0xFFFF, b=0xFFFE -> latency 4, a_gt_b=1.
5. Held start with changing a/b during SCAN -> ignored, result reflects the captured values. rst_n=0 during the second SCAN cycle -> no done, all flags 0, next start works normally.
6. start held high across DONE with new operands a=0x0001, b=0x0002 -> back-to-back capture in the DONE cycle, second done at latency 4 with a_lt_b=1, with no IDLE cycle between the two comparisons.
